crossbar_sched: RTL and testbench
=================================

# crossbar_sched

Per-output round-robin scheduler that generates the one-hot select vector for an N-port crossbar datapath. Each input port presents a valid/destination/last request stream. Each output port runs an independent arbiter that grants one input, holds the grant for a whole packet, then rotates priority. The block sits beside the crossbar: it drives the crossbar `sel` bus and returns per-input `ready` to the sources.

## Interface
- `N`, 16, number of input and output ports (≥2)
- `AW`, `$clog2(N)`, destination index width (derived; do not override)
- `clk`  input  1  clock; all state updates on the rising edge
- `rst`  input  1  synchronous, active-high reset
- `in_valid`  input  N  input i has a beat pending
- `in_dest`  input  N*AW  input i target output index at `[i*AW +: AW]`; held stable while `in_valid[i]`=1 until the last beat is accepted
- `in_last`  input  N  beat on input i is the final beat of its packet
- `in_ready`  output  N  beat on input i accepted this cycle when `in_valid[i]` && `in_ready[i]`
- `out_ready`  input  N  downstream of output j can accept a beat
- `out_valid`  output  N  output j carries a valid beat this cycle
- `sel`  output  N*N  crossbar select: `sel[j*N+i]`=1 routes input i to output j; one-hot or zero per output

## Operation
- Per-output state: IDLE, BUSY. Registered `owner[j]` (AW bits) and round-robin pointer `ptr[j]` (AW bits).
- Request vector for output j: `req_j[i] = in_valid[i] && in_dest[i]==j`.
- IDLE with `req_j`≠0: grant the first requesting i, searching upward from `ptr[j]+1` mod N with wrap-around. Next cycle: BUSY, `owner[j]`=i.
- IDLE with `req_j`=0: remain IDLE; `sel` for output j is all-zero.
- BUSY: `sel[j*N+owner[j]]`=1, `out_valid[j]` = `in_valid[owner[j]]`, `in_ready[owner[j]]` = `out_ready[j]`.
- A beat transfers when `in_valid` && `in_ready`. If the transferred beat has `in_last`=1: next cycle IDLE, `ptr[j]`=`owner[j]`.
- If the owner drops `in_valid` mid-packet, the grant is held. There is no timeout.
- `in_ready[i]`=0 for every input that is not a current owner.
- An input targets a single output, so it never owns two outputs.
- Simultaneous requests from several inputs to one output: exactly one is granted. The others see `in_ready`=0 and keep waiting.
- Requests to different outputs are arbitrated in parallel, independently.

## Timing
- Reset: all outputs IDLE, `ptr[j]`=N-1 (input 0 has first priority), `owner[j]`=0, `sel`=0, `in_ready`=0, `out_valid`=0.
- Reset asserted mid-packet aborts all grants on the next edge. Sources must restart their packets.
- Grant latency: request in cycle t (output IDLE) → `sel`/`in_ready` valid in cycle t+1. No beat moves in the arbitration cycle.
- `sel`, `owner`, `ptr` and state are registered. `in_ready` and `out_valid` are combinational from registered state and `in_valid`/`out_ready`.
- Release: last beat accepted in cycle t → IDLE in t+1 → new owner granted in t+2. There is one bubble cycle per packet per output.
- Throughput while BUSY: one beat per cycle when `in_valid` and `out_ready` are both high.

## Configuration
- `CROSSBAR_SCHED_PKT_EN` defined: grants are held until a beat with `in_last`=1 transfers (packet locking, as above).
- Not defined: `in_last` is ignored and every transferred beat is treated as last. The block re-arbitrates after every beat, so each output carries at most one beat per two cycles.

## Structure
- Package `crossbar_sched_pkg`: state enum (IDLE, BUSY) and an index-width helper function.
- Sub-module `rr_arbiter`: N-wide request vector and pointer in, one-hot grant and encoded index out, purely combinational. Instantiate it N times with a generate loop.
- State, owner and pointer registers stay in `crossbar_sched`.

## Test plan
- N=4, reset, then input 2 sends a 3-beat packet to output 1 with `out_ready`=1 → `sel[1*4+2]`=1 from cycle 1; beats accepted in cycles 1–3; IDLE in cycle 4; `ptr[1]`=2.
- Inputs 0, 1, 3 continuously request output 2 with single-beat packets → grant order 0,1,3,0,1,3, each grant 2 cycles apart.
- Inputs 0→out 3 and 1→out 0 requested in the same cycle → both granted in cycle 1; `sel`=`0x1002`.
- Owner drops `in_valid` for 2 cycles mid-packet while another input requests the same output → grant held, `sel` unchanged, competitor `in_ready`=0 throughout.
- `out_ready[j]`=0 for 3 cycles during BUSY → `in_ready[owner]`=0 and no beat lost; transfer resumes when `out_ready` returns to 1.
- Assert `rst` while two outputs are BUSY → next cycle `sel`=0, `in_ready`=0. The first post-reset contention between inputs 0 and 3 grants input 0.

Source files
------------

// File: rtl/crossbar_sched_pkg.sv
// Shared types for the crossbar scheduler (state encoding, index width helper).
// Optional packet locking is enabled by defining CROSSBAR_SCHED_PKT_EN.
package crossbar_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Width of an index into n ports; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/crossbar_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first request strictly after ptr, with wrap.
// Used by crossbar_sched (CROSSBAR_SCHED_PKT_EN has no effect here).
module rr_arbiter
  import crossbar_sched_pkg::*;
#(
  parameter int N  = 16,
  parameter int AW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [AW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [AW-1:0] idx,
  output logic          any
);

  always_comb begin
    int cand;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = AW'(cand);
      end
    end
  end

endmodule

// File: rtl/crossbar_sched.sv
// Per-output round-robin scheduler driving an N-port crossbar select bus.
// Define CROSSBAR_SCHED_PKT_EN to hold grants until in_last; otherwise every beat is last.
module crossbar_sched
  import crossbar_sched_pkg::*;
#(
  parameter int N  = 16,
  parameter int AW = idx_width(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    in_valid,
  input  logic [N*AW-1:0] in_dest,
  input  logic [N-1:0]    in_last,
  output logic [N-1:0]    in_ready,
  input  logic [N-1:0]    out_ready,
  output logic [N-1:0]    out_valid,
  output logic [N*N-1:0]  sel
);

  // Row j holds the in_ready contribution of output j (its owner bit when BUSY).
  logic [N-1:0][N-1:0] rdy_rows;

`ifndef CROSSBAR_SCHED_PKT_EN
  logic unused_last;
  assign unused_last = ^in_last;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_out
      state_e        state_q, state_d;
      logic [AW-1:0] owner_q, owner_d;
      logic [AW-1:0] ptr_q, ptr_d;
      logic [N-1:0]  sel_q, sel_d;
      logic [N-1:0]  req;
      logic [N-1:0]  grant;
      logic [AW-1:0] gidx;
      logic          gany;
      logic          xfer;
      logic          last;

      always_comb begin
        req = '0;
        for (int i = 0; i < N; i++) begin
          req[i] = in_valid[i] && (in_dest[i*AW +: AW] == AW'(gi));
        end
      end

      rr_arbiter #(.N(N), .AW(AW)) u_arb (
        .req   (req),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (gidx),
        .any   (gany)
      );

      // sel_q is the one-hot owner while BUSY and zero while IDLE.
      assign xfer = (|(sel_q & in_valid)) && out_ready[gi];

`ifdef CROSSBAR_SCHED_PKT_EN
      assign last = |(sel_q & in_last);
`else
      assign last = 1'b1;
`endif

      always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        case (state_q)
          IDLE: begin
            if (gany) begin
              state_d = BUSY;
              owner_d = gidx;
            end
          end
          BUSY: begin
            if (xfer && last) begin
              state_d = IDLE;
              ptr_d   = owner_q;
            end
          end
          default: state_d = IDLE;
        endcase
        sel_d = (state_d == BUSY) ? grant_vec(owner_d) : '0;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          state_q <= IDLE;
          owner_q <= '0;
          ptr_q   <= AW'(N - 1);
          sel_q   <= '0;
        end else begin
          state_q <= state_d;
          owner_q <= owner_d;
          ptr_q   <= ptr_d;
          sel_q   <= sel_d;
        end
      end

      assign sel[gi*N +: N] = sel_q;
      assign out_valid[gi]  = |(sel_q & in_valid);
      assign rdy_rows[gi]   = sel_q & {N{out_ready[gi]}};
    end
  endgenerate

  always_comb begin
    in_ready = '0;
    for (int j = 0; j < N; j++) begin
      in_ready = in_ready | rdy_rows[j];
    end
  end

  function automatic logic [N-1:0] grant_vec(input logic [AW-1:0] idx);
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      if (AW'(i) == idx) v[i] = 1'b1;
    end
    return v;
  endfunction

endmodule

// File: tb/tb_crossbar_sched.sv
// Self-checking bench for crossbar_sched (N=4): directed scenarios plus random traffic
// against a per-output round-robin reference model. Honours CROSSBAR_SCHED_PKT_EN.
module tb_crossbar_sched;
  localparam int N  = 4;
  localparam int AW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    in_valid;
  logic [N*AW-1:0] in_dest;
  logic [N-1:0]    in_last;
  logic [N-1:0]    in_ready;
  logic [N-1:0]    out_ready;
  logic [N-1:0]    out_valid;
  logic [N*N-1:0]  sel;

  crossbar_sched #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_dest   (in_dest),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .sel       (sel)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: per output, busy flag, owning input, round-robin pointer.
  int m_busy [N];
  int m_owner[N];
  int m_ptr  [N];

  // Source model: beats left in the current packet, its destination, stall flag.
  int   src_len [N];
  int   src_dest[N];
  logic src_hold[N];
  logic reload  [N];
  logic rand_en = 1'b0;
  logic [N-1:0] exp_rdy;

  int obs_q[$];
  int obs_t[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_update();
    for (int j = 0; j < N; j++) begin
      if (rst) begin
        m_busy[j] = 0; m_owner[j] = 0; m_ptr[j] = N - 1;
      end else if (m_busy[j] != 0) begin
        int o;
        logic is_last;
        o = m_owner[j];
`ifdef CROSSBAR_SCHED_PKT_EN
        is_last = in_last[o];
`else
        is_last = 1'b1;
`endif
        if (in_valid[o] && out_ready[j] && is_last) begin
          m_busy[j] = 0;
          m_ptr[j]  = o;
        end
      end else begin
        for (int k = 1; k <= N; k++) begin
          int i;
          i = (m_ptr[j] + k) % N;
          if (m_busy[j] == 0 && in_valid[i] && int'(in_dest[i*AW +: AW]) == j) begin
            m_busy[j]  = 1;
            m_owner[j] = i;
          end
        end
      end
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      in_valid[i]          = (src_len[i] > 0) && !src_hold[i];
      in_last[i]           = (src_len[i] == 1);
      in_dest[i*AW +: AW]  = AW'(src_dest[i]);
    end
  endtask

  task automatic start_pkt(input int i, input int dest, input int len);
    src_dest[i] = dest;
    src_len[i]  = len;
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < N; i++) begin
      src_len[i] = 0; src_hold[i] = 1'b0; reload[i] = 1'b0;
    end
  endtask

  task automatic gen();
    for (int i = 0; i < N; i++) begin
      if (src_len[i] == 0) begin
        if ($urandom_range(2) == 0) start_pkt(i, $urandom_range(N - 1), $urandom_range(4, 1));
        src_hold[i] = 1'b0;
      end else begin
        src_hold[i] = ($urandom_range(4) == 0);
      end
      out_ready[i] = ($urandom_range(3) != 0);
    end
  endtask

  task automatic step();
    logic [N*N-1:0] es;
    logic [N-1:0]   er, eo;
    @(negedge clk);
    es = '0; er = '0; eo = '0;
    for (int j = 0; j < N; j++) begin
      if (m_busy[j] != 0) begin
        es[j*N + m_owner[j]] = 1'b1;
        eo[j] = in_valid[m_owner[j]];
        if (out_ready[j]) er[m_owner[j]] = 1'b1;
      end
    end
    chk("sel", 32'(sel), 32'(es));
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("out_valid", 32'(out_valid), 32'(eo));
    exp_rdy = er;
    for (int i = 0; i < N; i++) begin
      if (in_valid[i] && in_ready[i]) begin
        $display("beat cycle=%0d in=%0d out=%0d last=%0b", cyc, i, in_dest[i*AW +: AW], in_last[i]);
        obs_q.push_back(i);
        obs_t.push_back(cyc);
      end
    end
    @(posedge clk);
    model_update();
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        src_len[i] = 0;
      end else if (in_valid[i] && exp_rdy[i]) begin
        src_len[i]--;
        if (src_len[i] == 0 && reload[i]) src_len[i] = 1;
      end
    end
    if (rand_en) gen();
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_srcs();
    out_ready = '1;
    drive();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int exp_order[6] = '{0, 1, 3, 0, 1, 3};
    rst = 1'b1;
    out_ready = '1;
    clear_srcs();
    for (int j = 0; j < N; j++) begin m_busy[j] = 0; m_owner[j] = 0; m_ptr[j] = N - 1; end
    drive();
    @(posedge clk);
    model_update();
    #1;
    chk("reset_sel", 32'(sel), 32'h0);
    chk("reset_in_ready", 32'(in_ready), 32'h0);
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    rst = 1'b0;

    // Input 2 sends 3 beats to output 1.
    start_pkt(2, 1, 3); drive();
    step();
    chk("pkt_grant_sel", 32'(sel), 32'h0040);
    repeat (5) step();

    // Parallel grants to different outputs.
    do_reset();
    start_pkt(0, 3, 2); start_pkt(1, 0, 2); drive();
    step();
    chk("parallel_sel", 32'(sel), 32'h1002);
    repeat (5) step();

    // Round-robin order among inputs 0, 1, 3 on output 2.
    do_reset();
    obs_q.delete(); obs_t.delete();
    for (int i = 0; i < N; i++) if (i != 2) begin start_pkt(i, 2, 1); reload[i] = 1'b1; end
    drive();
    repeat (14) step();
    chk("order_count", 32'(obs_q.size() >= 6), 32'h1);
    for (int k = 0; k < 6; k++) begin
      chk("order", (k < obs_q.size()) ? 32'(obs_q[k]) : 32'd99, 32'(exp_order[k]));
      if (k > 0) chk("gap", (k < obs_t.size()) ? 32'(obs_t[k] - obs_t[k-1]) : 32'd99, 32'd2);
    end

    // Owner stalls mid-packet while a competitor waits.
    do_reset();
    start_pkt(0, 1, 3); drive();
    step(); step();
    src_hold[0] = 1'b1; start_pkt(2, 1, 1); drive();
    step(); step();
    src_hold[0] = 1'b0; drive();
    repeat (6) step();

    // Downstream back-pressure for 3 cycles.
    do_reset();
    start_pkt(3, 0, 3); drive();
    step();
    out_ready[0] = 1'b0; drive();
    repeat (3) step();
    out_ready[0] = 1'b1; drive();
    repeat (5) step();

    // Reset while two outputs are busy, then contention between inputs 0 and 3.
    do_reset();
    start_pkt(0, 0, 4); start_pkt(1, 1, 4); drive();
    step();
    chk("busy_two_sel", 32'(sel), 32'h0021);
    step();
    do_reset();
    chk("abort_sel", 32'(sel), 32'h0);
    chk("abort_in_ready", 32'(in_ready), 32'h0);
    start_pkt(0, 2, 1); start_pkt(3, 2, 1); drive();
    step();
    chk("post_reset_prio", 32'(sel[2*N +: N]), 32'h1);
    repeat (4) step();

    // Random traffic.
    do_reset();
    rand_en = 1'b1;
    repeat (500) step();
    rand_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
